debouncer_multi: RTL and testbench
==================================

DEBOUNCER_MULTI -- requirements
Module: debouncer_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent input channels (1..32).
REQ-002 SHALL have parameter NUM_STAGES, default 2: synchronizer flop depth per channel (2..4).
REQ-003 SHALL have parameter STABLE_CYCLES, default 100: consecutive synchronized cycles required to accept a new level (>=1).
REQ-004 SHALL have parameter RESET_VAL, default 0: level loaded into every synchronizer flop and debounced output at reset.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port noisy_in, input, NUM_CH bits: raw asynchronous channel inputs.
REQ-008 SHALL have port debouncer_out, output, NUM_CH bits: registered debounced levels.
REQ-009 SHALL have port rise_pulse, output, NUM_CH bits: one-cycle pulse when debouncer_out goes 0->1.
REQ-010 SHALL have port fall_pulse, output, NUM_CH bits: one-cycle pulse when debouncer_out goes 1->0.
REQ-011 SHALL have port busy, output, NUM_CH bits: high while a channel is qualifying a candidate level.

Function
REQ-012 SHALL synchronize each noisy_in bit through NUM_STAGES flops; the last stage output s[i] is the only value the channel FSM sees.
REQ-013 SHALL run one FSM per channel with states STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW; debouncer_out[i] = 1 in STABLE_HIGH and WAIT_LOW, else 0.
REQ-014 SHALL go STABLE_LOW->WAIT_HIGH (or STABLE_HIGH->WAIT_LOW) on the edge where s[i] differs from debouncer_out[i], loading count to 1.
REQ-015 SHALL, in a WAIT state, increment count on each edge where s[i] still equals the candidate level, and return to the prior STABLE state with count=0 on any edge where it does not.
REQ-016 SHALL move to the candidate STABLE state when count equals STABLE_CYCLES and s[i] still equals the candidate, so debouncer_out toggles exactly NUM_STAGES+STABLE_CYCLES edges after a clean input step (+1 for async sampling).
REQ-017 SHALL, for STABLE_CYCLES=1, accept a changed level on the edge after entering WAIT without further delay.
REQ-018 SHALL size count to $clog2(STABLE_CYCLES+1) bits; count never wraps and holds 0 in STABLE states.
REQ-019 SHALL assert busy[i] in WAIT_HIGH and WAIT_LOW only.
REQ-020 SHALL register rise_pulse[i]/fall_pulse[i] high for exactly the one cycle following the debouncer_out[i] transition; never both high together.
REQ-021 SHALL keep channels fully independent; simultaneous events on several channels SHALL each behave as if alone.
REQ-022 SHALL reject any glitch shorter than STABLE_CYCLES synchronized cycles with no change on debouncer_out, rise_pulse or fall_pulse.

Reset
REQ-023 SHALL, on rst asserted (asynchronous, any time incl. mid-qualification), force synchronizer flops and debouncer_out to RESET_VAL, FSM to STABLE_LOW/STABLE_HIGH matching RESET_VAL, count=0, busy=0, rise_pulse=0, fall_pulse=0.
REQ-024 SHALL produce no edge pulse on reset deassertion.

Configuration
REQ-025 SHALL, with macro DEBOUNCER_EDGE_PULSE_EN defined, implement rise_pulse/fall_pulse per REQ-020.
REQ-026 SHALL, without DEBOUNCER_EDGE_PULSE_EN, tie rise_pulse and fall_pulse to 0 and instantiate no pulse registers; ports remain present.

Structure
REQ-027 SHALL place the channel state enum and the state-width constant in shared package debouncer_pkg.
REQ-028 SHALL implement one channel (synchronizer, FSM, counter, pulse logic) in sub-module debouncer_ch, instantiated NUM_CH times by generate.

Verification (NUM_CH=4, NUM_STAGES=2, STABLE_CYCLES=100, RESET_VAL=0, 10 ns clock)
REQ-029 SHALL check: reset then idle 200 cycles -> debouncer_out=4'b0000, busy=0, no pulses.
REQ-030 SHALL check: ch0 bounces 20 toggles at 1.6-10 ns spacing then holds 1 -> debouncer_out[0] rises 102+/-1 edges after last toggle, rise_pulse[0] high one cycle.
REQ-031 SHALL check: ch0 stable high, 1->0 glitch of 50 cycles -> debouncer_out[0] stays 1, busy[0] high 50+/-1 cycles, no fall_pulse.
REQ-032 SHALL check: ch1 and ch3 step 0->1 same cycle while ch2 bounces -> ch1/ch3 rise same edge, ch2 unaffected.
REQ-033 SHALL check: rst asserted at count=60 of a WAIT_HIGH -> immediate debouncer_out=0, busy=0, count restart from 0 after release.
REQ-034 SHALL check: build without DEBOUNCER_EDGE_PULSE_EN, repeat REQ-030 -> rise_pulse/fall_pulse constantly 0, debouncer_out timing unchanged.

Source files
------------

// File: rtl/debouncer_pkg.sv
// Shared definitions for the multi-channel debouncer: per-channel FSM state
// encoding and the level decode used by every channel.
package debouncer_pkg;

  localparam int unsigned CH_STATE_W = 2;

  typedef enum logic [CH_STATE_W-1:0] {
    ST_STABLE_LOW  = 2'd0,
    ST_WAIT_HIGH   = 2'd1,
    ST_STABLE_HIGH = 2'd2,
    ST_WAIT_LOW    = 2'd3
  } ch_state_t;

  // Debounced level implied by a state: high while accepted-high or qualifying a fall.
  function automatic logic level_of(input ch_state_t st);
    return (st == ST_STABLE_HIGH) || (st == ST_WAIT_LOW);
  endfunction

endpackage

// File: rtl/debouncer_ch.sv
// One debouncer channel: NUM_STAGES synchronizer, qualification FSM/counter,
// optional edge pulses (enabled by macro DEBOUNCER_EDGE_PULSE_EN).
module debouncer_ch
  import debouncer_pkg::*;
#(
  parameter int unsigned NUM_STAGES    = 2,
  parameter int unsigned STABLE_CYCLES = 100,
  parameter bit          RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic noisy_in,
  output logic debouncer_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int unsigned     CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam ch_state_t       ST_RST  = RESET_VAL ? ST_STABLE_HIGH : ST_STABLE_LOW;

  logic [NUM_STAGES-1:0] r_sync;
  ch_state_t             r_state;
  ch_state_t             w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_out;
  logic                  w_out_nxt;
  logic                  w_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= {NUM_STAGES{RESET_VAL}};
    else     r_sync <= {r_sync[NUM_STAGES-2:0], noisy_in};
  end

  assign w_s = r_sync[NUM_STAGES-1];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_STABLE_LOW: begin
        if (w_s) begin
          w_state_nxt = ST_WAIT_HIGH;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      ST_WAIT_HIGH: begin
        if (!w_s) begin
          w_state_nxt = ST_STABLE_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = ST_STABLE_HIGH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_STABLE_HIGH: begin
        if (!w_s) begin
          w_state_nxt = ST_WAIT_LOW;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      ST_WAIT_LOW: begin
        if (w_s) begin
          w_state_nxt = ST_STABLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = ST_STABLE_LOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_STABLE_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_out_nxt = level_of(w_state_nxt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RST;
      r_cnt   <= '0;
      r_out   <= RESET_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign debouncer_out = r_out;
  assign busy          = (r_state == ST_WAIT_HIGH) || (r_state == ST_WAIT_LOW);

`ifdef DEBOUNCER_EDGE_PULSE_EN
  logic r_rise;
  logic r_fall;

  // Pulses load on the same edge as the level change, so they cover its first cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_out_nxt & ~r_out;
      r_fall <= ~w_out_nxt & r_out;
    end
  end

  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
`else
  assign rise_pulse = 1'b0;
  assign fall_pulse = 1'b0;
`endif

endmodule

// File: rtl/debouncer_multi.sv
// NUM_CH independent debouncer channels; edge pulses present only when
// macro DEBOUNCER_EDGE_PULSE_EN is defined, otherwise tied low.
module debouncer_multi
  import debouncer_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned NUM_STAGES    = 2,
  parameter int unsigned STABLE_CYCLES = 100,
  parameter bit          RESET_VAL     = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] noisy_in,
  output logic [NUM_CH-1:0] debouncer_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [NUM_CH-1:0] busy
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debouncer_ch #(
      .NUM_STAGES   (NUM_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .RESET_VAL    (RESET_VAL)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .noisy_in     (noisy_in[g]),
      .debouncer_out(debouncer_out[g]),
      .rise_pulse   (rise_pulse[g]),
      .fall_pulse   (fall_pulse[g]),
      .busy         (busy[g])
    );
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi (4 ch, 2 stages, 100 stable cycles);
// expectations follow DEBOUNCER_EDGE_PULSE_EN. Delay unit: 100 units = 1 clock.
module tb_debouncer_multi;

`ifdef DEBOUNCER_EDGE_PULSE_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] noisy_in;
  logic [3:0] debouncer_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic [3:0] busy;

  int n_checks = 0;
  int n_errors = 0;
  int rise_cnt [4];
  int fall_cnt [4];
  int busy_cnt [4];
  int low_cnt  [4];
  int both_seen = 0;
  int out_or, busy_or;

  debouncer_multi #(
    .NUM_CH       (4),
    .NUM_STAGES   (2),
    .STABLE_CYCLES(100),
    .RESET_VAL    (1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .noisy_in     (noisy_in),
    .debouncer_out(debouncer_out),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .busy         (busy)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_acc();
    for (int c = 0; c < 4; c++) begin
      rise_cnt[c] = 0; fall_cnt[c] = 0; busy_cnt[c] = 0; low_cnt[c] = 0;
    end
    out_or = 0; busy_or = 0;
  endtask

  // Advance one clock and sample 10 units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #10;
    for (int c = 0; c < 4; c++) begin
      rise_cnt[c] += int'(rise_pulse[c]);
      fall_cnt[c] += int'(fall_pulse[c]);
      busy_cnt[c] += int'(busy[c]);
      low_cnt[c]  += int'(!debouncer_out[c]);
    end
    if ((rise_pulse & fall_pulse) != 4'b0) both_seen++;
    out_or  = out_or | int'(debouncer_out);
    busy_or = busy_or | int'(busy);
  endtask

  initial begin
    int n, t1, t3;
    rst = 1'b1;
    noisy_in = 4'b0000;
    clr_acc();

    // Reset state, then 200 idle cycles.
    repeat (3) tick();
    check("rst_out", debouncer_out, 4'b0000);
    check("rst_busy", busy, 4'b0000);
    check("rst_rise", rise_pulse, 4'b0000);
    check("rst_fall", fall_pulse, 4'b0000);
    #20 rst = 1'b0;
    clr_acc();
    repeat (200) tick();
    check("idle_out", out_or, 0);
    check("idle_busy", busy_or, 0);
    check("idle_pulses", rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3]
                         + fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3], 0);

    // ch0 bounce, then clean step to 1: rises on the 103rd edge after the step.
    for (int i = 0; i < 20; i++) begin
      noisy_in[0] = ~noisy_in[0];
      #(16 + (i * 37) % 85);
    end
    @(posedge clk);
    #30 noisy_in[0] = 1'b1;
    clr_acc();
    n = 0;
    while (n < 300 && !debouncer_out[0]) begin tick(); n++; end
    check("bounce_latency", n, 103);
    check("bounce_rise_now", rise_pulse[0], PE);
    tick();
    check("bounce_rise_after", rise_pulse[0], 0);
    check("bounce_rise_cnt", rise_cnt[0], PE);
    check("bounce_fall_cnt", fall_cnt[0], 0);

    // 50-cycle low glitch on stable-high ch0 is rejected; busy for 50 cycles.
    noisy_in[0] = 1'b0;
    clr_acc();
    repeat (50) tick();
    noisy_in[0] = 1'b1;
    repeat (60) tick();
    check("glitch_busy_cycles", busy_cnt[0], 50);
    check("glitch_out_low", low_cnt[0], 0);
    check("glitch_fall_cnt", fall_cnt[0], 0);
    check("glitch_busy_end", busy[0], 0);

    // ch1/ch3 step together while ch2 bounces and settles back to 0.
    clr_acc();
    noisy_in[1] = 1'b1;
    noisy_in[3] = 1'b1;
    t1 = 0; t3 = 0;
    fork
      for (int i = 0; i < 40; i++) begin
        #73 noisy_in[2] = ~noisy_in[2];
      end
      for (int k = 1; k <= 150; k++) begin
        tick();
        if (t1 == 0 && debouncer_out[1]) t1 = k;
        if (t3 == 0 && debouncer_out[3]) t3 = k;
      end
    join
    check("multi_ch1_latency", t1, 103);
    check("multi_ch3_latency", t3, 103);
    check("multi_ch2_low", low_cnt[2], 150);
    check("multi_ch2_rise", rise_cnt[2], 0);
    check("multi_ch1_rise", rise_cnt[1], PE);
    check("multi_ch3_rise", rise_cnt[3], PE);
    check("multi_ch0_hold", low_cnt[0], 0);

    // ch3 clean fall.
    clr_acc();
    noisy_in[3] = 1'b0;
    n = 0;
    while (n < 300 && debouncer_out[3]) begin tick(); n++; end
    check("fall_latency", n, 103);
    check("fall_pulse_now", fall_pulse[3], PE);
    tick();
    check("fall_cnt", fall_cnt[3], PE);
    check("fall_rise_cnt", rise_cnt[3], 0);

    // Reset at count 60 of ch2 WAIT_HIGH; qualification restarts from zero.
    noisy_in[2] = 1'b1;
    repeat (62) tick();
    check("pre_rst_busy2", busy[2], 1);
    rst = 1'b1;
    #5;
    check("mid_rst_out", debouncer_out, 4'b0000);
    check("mid_rst_busy", busy, 4'b0000);
    check("mid_rst_pulses", {rise_pulse, fall_pulse}, 8'h00);
    repeat (2) tick();
    #20 rst = 1'b0;
    clr_acc();
    repeat (102) tick();
    check("rel_out_102", debouncer_out, 4'b0000);
    check("rel_busy_102", busy, 4'b0111);
    check("rel_busy2_cycles", busy_cnt[2], 100);
    check("rel_no_pulse", rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3]
                          + fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3], 0);
    tick();
    check("rel_out_103", debouncer_out, 4'b0111);
    check("rel_busy_103", busy, 4'b0000);
    check("rel_rise_103", rise_pulse, (PE != 0) ? 4'b0111 : 4'b0000);

    check("never_both_pulses", both_seen, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
